// File: rtl/seg7_readback.sv
// Multiplexed 7-segment bus readback: debounces each (segments, digit select) pattern
// and decodes it back to a per-digit hex nibble, flagging illegal patterns and selects.
module seg7_readback #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic                    update,
    output logic                    bad_pattern,
    output logic                    sel_error
);

    localparam int RW = $clog2(STABLE_CYCLES + 1);
    localparam logic [RW-1:0] SC = RW'(STABLE_CYCLES);

    logic [6:0]            prev_seg;
    logic [NUM_DIGITS-1:0] prev_sel;
    logic [RW-1:0]         run;
    logic [RW-1:0]         run_next;
    logic [NUM_DIGITS-1:0] sel_m1;
    logic                  sel_onehot;
    logic                  capture;
    logic                  pat_legal;
    logic                  pat_blank;
    logic [3:0]            pat_nib;

    assign sel_m1     = dig_sel - NUM_DIGITS'(1);
    assign sel_onehot = (dig_sel != '0) && ((dig_sel & sel_m1) == '0);

    // Run length saturates at SC so a long stable window yields one capture only
    always_comb begin
        run_next = '0;
        if (!sel_onehot)
            run_next = '0;
        else if (seg_in == prev_seg && dig_sel == prev_sel && run != '0)
            run_next = (run == SC) ? SC : run + RW'(1);
        else
            run_next = RW'(1);
    end

    assign capture = sel_onehot && (run_next == SC) && (run != SC);

    always_comb begin
        pat_legal = 1'b1;
        pat_blank = 1'b0;
        pat_nib   = 4'h0;
        case (seg_in)
            7'b1111110: pat_nib = 4'h0;
            7'b0110000: pat_nib = 4'h1;
            7'b1101101: pat_nib = 4'h2;
            7'b1111001: pat_nib = 4'h3;
            7'b0110011: pat_nib = 4'h4;
            7'b1011011: pat_nib = 4'h5;
            7'b1011111: pat_nib = 4'h6;
            7'b1110000: pat_nib = 4'h7;
            7'b1111111: pat_nib = 4'h8;
            7'b1111011: pat_nib = 4'h9;
            7'b1110111: pat_nib = 4'hA;
            7'b0011111: pat_nib = 4'hB;
            7'b1001110: pat_nib = 4'hC;
            7'b0111101: pat_nib = 4'hD;
            7'b1001111: pat_nib = 4'hE;
            7'b1000111: pat_nib = 4'hF;
            7'b0000000: begin
                pat_legal = 1'b0;
                pat_blank = 1'b1;
            end
            default:    pat_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_seg    <= '0;
            prev_sel    <= '0;
            run         <= '0;
            hex_out     <= '0;
            digit_valid <= '0;
            digit_blank <= '0;
            update      <= 1'b0;
            bad_pattern <= 1'b0;
            sel_error   <= 1'b0;
        end else begin
            prev_seg    <= seg_in;
            prev_sel    <= dig_sel;
            run         <= run_next;
            update      <= capture;
            bad_pattern <= capture && !pat_legal && !pat_blank;
            sel_error   <= (dig_sel != '0) && !sel_onehot;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && dig_sel[i]) begin
                    if (pat_legal) begin
                        hex_out[4*i +: 4] <= pat_nib;
                        digit_valid[i]    <= 1'b1;
                        digit_blank[i]    <= 1'b0;
                    end else begin
                        digit_valid[i]    <= 1'b0;
                        digit_blank[i]    <= pat_blank;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_readback.sv
// Randomized and directed bench for seg7_readback against a streak-counting reference model.
module tb_seg7_readback;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    seg_in = '0;
    logic [ND-1:0] dig_sel = '0;
    logic [4*ND-1:0] hex_out;
    logic [ND-1:0] digit_valid;
    logic [ND-1:0] digit_blank;
    logic          update;
    logic          bad_pattern;
    logic          sel_error;

    int errors = 0;
    int checks = 0;

    seg7_readback #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .reset(reset), .seg_in(seg_in), .dig_sel(dig_sel),
        .hex_out(hex_out), .digit_valid(digit_valid), .digit_blank(digit_blank),
        .update(update), .bad_pattern(bad_pattern), .sel_error(sel_error)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [6:0]      codes [16];
    int              streak = 0;
    logic [6:0]      m_seg = '0;
    logic [ND-1:0]   m_sel = '0;
    logic [4*ND-1:0] exp_hex = '0;
    logic [ND-1:0]   exp_valid = '0;
    logic [ND-1:0]   exp_blank = '0;
    logic            exp_upd = 1'b0;
    logic            exp_bad = 1'b0;
    logic            exp_serr = 1'b0;

    wire [4*ND+2*ND+2:0] obs  = {hex_out, digit_valid, digit_blank, update, bad_pattern, sel_error};
    wire [4*ND+2*ND+2:0] expv = {exp_hex, exp_valid, exp_blank, exp_upd, exp_bad, exp_serr};

    // 0..15 = hex digit, 16 = blank, -1 = illegal
    function automatic int decode(input logic [6:0] s);
        if (s == 7'b0000000) return 16;
        for (int k = 0; k < 16; k++)
            if (codes[k] == s) return k;
        return -1;
    endfunction

    task automatic model_edge(input logic [6:0] s, input logic [ND-1:0] d, input logic r);
        int code;
        int idx;
        exp_upd  = 1'b0;
        exp_bad  = 1'b0;
        exp_serr = 1'b0;
        if (r) begin
            streak = 0; m_seg = '0; m_sel = '0;
            exp_hex = '0; exp_valid = '0; exp_blank = '0;
        end else begin
            if ($countones(d) != 1) begin
                streak   = 0;
                exp_serr = (d != '0);
            end else if (streak > 0 && s == m_seg && d == m_sel) begin
                streak++;
            end else begin
                streak = 1;
            end
            if ($countones(d) == 1 && streak == SC) begin
                idx = 0;
                for (int k = 0; k < ND; k++) if (d[k]) idx = k;
                code    = decode(s);
                exp_upd = 1'b1;
                if (code >= 0 && code < 16) begin
                    exp_hex[4*idx +: 4] = 4'(code);
                    exp_valid[idx] = 1'b1;
                    exp_blank[idx] = 1'b0;
                end else begin
                    exp_valid[idx] = 1'b0;
                    exp_blank[idx] = (code == 16);
                    exp_bad        = (code == -1);
                end
            end
            m_seg = s;
            m_sel = d;
        end
    endtask

    task automatic step(input logic [6:0] s, input logic [ND-1:0] d, input logic r);
        seg_in  = s;
        dig_sel = d;
        reset   = r;
        @(posedge clk);
        model_edge(s, d, r);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(7'b1111111, 4'b0001, 1'b1);
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL reset_zero: got %h required 0", obs);
            end
        end
        for (int k = 1; k <= 5; k++) begin
            step(7'b1111111, 4'b0001, 1'b0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL reset_release_model edge %0d: got %h required %h", k, obs, expv);
            end
            checks++;
            if (update !== (k == 4)) begin
                errors++;
                $display("FAIL reset_release_update edge %0d: got %b required %b", k, update, (k == 4));
            end
        end
        checks++;
        if (hex_out[3:0] !== 4'h8 || digit_valid !== 4'b0001) begin
            errors++;
            $display("FAIL reset_capture: hex=%h valid=%b required 8/0001", hex_out[3:0], digit_valid);
        end
    endtask

    task automatic test_stability();
        int ups = 0;
        for (int k = 0; k < 7; k++) begin
            step((k < 3) ? 7'b1011011 : 7'b0110000, 4'b0010, 1'b0);
            ups += int'(update);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL stability_model edge %0d: got %h required %h", k, obs, expv);
            end
        end
        checks++;
        if (hex_out[7:4] !== 4'h1 || ups != 1) begin
            errors++;
            $display("FAIL stability_capture: hex=%h updates=%0d required 1/1", hex_out[7:4], ups);
        end
    endtask

    task automatic test_full_scan();
        int ups = 0;
        logic [6:0] pats [4];
        pats[0] = 7'b1110111; pats[1] = 7'b0011111; pats[2] = 7'b1001110; pats[3] = 7'b0111101;
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 5; k++) begin
                step(pats[d], 4'(1 << d), 1'b0);
                ups += int'(update);
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL scan_model digit %0d edge %0d: got %h required %h", d, k, obs, expv);
                end
            end
        end
        checks++;
        if (hex_out !== 16'hDCBA || digit_valid !== 4'b1111 || ups != 4) begin
            errors++;
            $display("FAIL full_scan: hex=%h valid=%b updates=%0d required DCBA/1111/4", hex_out, digit_valid, ups);
        end
    endtask

    task automatic test_blank_illegal();
        int bads = 0;
        for (int k = 0; k < 4; k++) step(7'b1011011, 4'b0001, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(7'b0000000, 4'b0001, 1'b0);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL blank_model edge %0d: got %h required %h", k, obs, expv);
            end
        end
        checks++;
        if (digit_blank[0] !== 1'b1 || digit_valid[0] !== 1'b0 || hex_out[3:0] !== 4'h5) begin
            errors++;
            $display("FAIL blank_capture: blank=%b valid=%b hex=%h required 1/0/5",
                     digit_blank[0], digit_valid[0], hex_out[3:0]);
        end
        for (int k = 0; k < 4; k++) begin
            step(7'b1010101, 4'b0001, 1'b0);
            bads += int'(bad_pattern);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL illegal_model edge %0d: got %h required %h", k, obs, expv);
            end
        end
        checks++;
        if (bads != 1 || digit_blank[0] !== 1'b0 || digit_valid[0] !== 1'b0 || hex_out[3:0] !== 4'h5) begin
            errors++;
            $display("FAIL illegal_capture: bad_pulses=%0d blank=%b valid=%b hex=%h required 1/0/0/5",
                     bads, digit_blank[0], digit_valid[0], hex_out[3:0]);
        end
    endtask

    task automatic test_bad_select();
        logic [4*ND-1:0] hex_before;
        hex_before = hex_out;
        for (int k = 0; k < 6; k++) begin
            step(7'b1111110, 4'b0011, 1'b0);
            checks++;
            if (sel_error !== 1'b1 || update !== 1'b0 || hex_out !== hex_before || obs !== expv) begin
                errors++;
                $display("FAIL bad_select edge %0d: sel_error=%b update=%b hex=%h required 1/0/%h",
                         k, sel_error, update, hex_out, hex_before);
            end
        end
        for (int k = 0; k < 2; k++) begin
            step(7'b1111110, 4'b0000, 1'b0);
            checks++;
            if (sel_error !== 1'b0 || update !== 1'b0) begin
                errors++;
                $display("FAIL idle_select edge %0d: sel_error=%b update=%b required 0/0", k, sel_error, update);
            end
        end
    endtask

    task automatic test_reset_midrun();
        step(7'b1110000, 4'b0001, 1'b0);
        step(7'b1110000, 4'b0001, 1'b0);
        step(7'b1110000, 4'b0001, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            step(7'b1110000, 4'b0001, 1'b0);
            checks++;
            if (update !== (k == 4) || obs !== expv) begin
                errors++;
                $display("FAIL reset_midrun edge %0d: update=%b obs=%h required %b/%h", k, update, obs, (k == 4), expv);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0]    s;
        logic [ND-1:0] d;
        int            hold;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0:       s = 7'($urandom);
                1:       s = 7'b0000000;
                default: s = codes[$urandom_range(0, 15)];
            endcase
            case ($urandom_range(0, 9))
                0:       d = '0;
                1:       d = 4'($urandom);
                default: d = 4'(1 << $urandom_range(0, ND - 1));
            endcase
            hold = $urandom_range(1, 6);
            for (int k = 0; k < hold; k++) begin
                step(s, d, ($urandom_range(0, 60) == 0));
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL random_model txn %0d edge %0d: got %h required %h", n, k, obs, expv);
                end
            end
        end
    endtask

    initial begin
        codes[0]  = 7'b1111110; codes[1]  = 7'b0110000; codes[2]  = 7'b1101101; codes[3]  = 7'b1111001;
        codes[4]  = 7'b0110011; codes[5]  = 7'b1011011; codes[6]  = 7'b1011111; codes[7]  = 7'b1110000;
        codes[8]  = 7'b1111111; codes[9]  = 7'b1111011; codes[10] = 7'b1110111; codes[11] = 7'b0011111;
        codes[12] = 7'b1001110; codes[13] = 7'b0111101; codes[14] = 7'b1001111; codes[15] = 7'b1000111;
        @(negedge clk);
        test_reset();
        test_stability();
        test_full_scan();
        test_blank_illegal();
        test_bad_select();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
